// File: rtl/idct_pkg.sv
// Shared definitions for the 4x4 inverse Walsh-Hadamard receive block.
//   state_t : controller states, in the order a block moves through them
//   N       : transform size (points per row/column)
//   NCOEF   : coefficients per block
//   RND     : rounding offset added before the final shift
//   SHF     : final normalising shift (divide by 16)
package idct_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROW,
    COL,
    OUT
  } state_t;

  localparam int N     = 4;
  localparam int NCOEF = 16;
  localparam int RND   = 8;
  localparam int SHF   = 4;

endpackage

// File: rtl/hadamard4.sv
// Combinational 4-point Walsh-Hadamard butterfly, y_i = sum_k H[k][i] * x_k,
// with H rows [1 1 1 1], [1 1 -1 -1], [1 -1 -1 1], [1 -1 1 -1].
// Ports:
//   i_x0..i_x3 : W-bit signed inputs
//   o_y0..o_y3 : (W+2)-bit signed outputs (two bits of growth for four terms)
module hadamard4 #(
  parameter int W = 12
) (
  input  logic signed [W-1:0] i_x0,
  input  logic signed [W-1:0] i_x1,
  input  logic signed [W-1:0] i_x2,
  input  logic signed [W-1:0] i_x3,
  output logic signed [W+1:0] o_y0,
  output logic signed [W+1:0] o_y1,
  output logic signed [W+1:0] o_y2,
  output logic signed [W+1:0] o_y3
);

  logic signed [W+1:0] w_e0, w_e1, w_e2, w_e3;
  logic signed [W+1:0] w_a, w_b, w_d, w_e;

  assign w_e0 = {{2{i_x0[W-1]}}, i_x0};
  assign w_e1 = {{2{i_x1[W-1]}}, i_x1};
  assign w_e2 = {{2{i_x2[W-1]}}, i_x2};
  assign w_e3 = {{2{i_x3[W-1]}}, i_x3};

  // Two-stage butterfly: pairwise sums/differences, then combine.
  assign w_a = w_e0 + w_e1;
  assign w_b = w_e2 + w_e3;
  assign w_d = w_e0 - w_e1;
  assign w_e = w_e2 - w_e3;

  assign o_y0 = w_a + w_b;
  assign o_y1 = w_a - w_b;
  assign o_y2 = w_d - w_e;
  assign o_y3 = w_d + w_e;

endmodule

// File: rtl/idct4x4_rx.sv
// Inverse 4x4 Walsh-Hadamard transform, serial in / serial out.
// A block of 16 coefficients (row-major) is loaded, transformed in place by a
// row pass and a column pass through one shared butterfly, then emitted as 16
// rounded and clamped pixels (row-major).
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous reset, active-high
//   in_valid  : in_data carries a coefficient this cycle
//   in_data   : CW-bit signed coefficient
//   out_valid : out_data carries a pixel this cycle
//   out_data  : PW-bit unsigned pixel, zero whenever out_valid is low
module idct4x4_rx
  import idct_pkg::*;
#(
  parameter int CW = 10,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [CW-1:0] in_data,
  output logic          out_valid,
  output logic [PW-1:0] out_data
);

  localparam int BW = CW + 2;  // butterfly input width
  localparam int MW = CW + 4;  // storage / butterfly output width

  state_t r_state, w_next;
  logic [3:0]  r_cnt;
  logic [1:0]  r_pass;
  logic signed [MW-1:0] r_mem [NCOEF];
  logic          r_out_valid;
  logic [PW-1:0] r_out_data;

  logic signed [MW-1:0] w_in_ext;
  logic signed [BW-1:0] w_x [N];
  logic signed [MW-1:0] w_y [N];
  logic signed [MW:0]   w_rnd, w_shf;
  logic [PW-1:0]        w_pix;

  assign w_in_ext = {{(MW-CW){in_data[CW-1]}}, in_data};

  // Row pass reads row r_pass; column pass reads column r_pass. Row-pass
  // values are sign-extended coefficients, column-pass values are row results
  // that fit BW bits, so the low BW bits carry the full value in both cases.
  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
      w_x[k] = '0;
    end
    if (r_state == ROW) begin
      for (int unsigned k = 0; k < N; k++) begin
        w_x[k] = r_mem[{r_pass, 2'(k)}][BW-1:0];
      end
    end else if (r_state == COL) begin
      for (int unsigned k = 0; k < N; k++) begin
        w_x[k] = r_mem[{2'(k), r_pass}][BW-1:0];
      end
    end
  end

  hadamard4 #(.W(BW)) u_bfly (
    .i_x0 (w_x[0]),
    .i_x1 (w_x[1]),
    .i_x2 (w_x[2]),
    .i_x3 (w_x[3]),
    .o_y0 (w_y[0]),
    .o_y1 (w_y[1]),
    .o_y2 (w_y[2]),
    .o_y3 (w_y[3])
  );

  // Round, arithmetic shift, clamp to [0, 2**PW-1].
  assign w_rnd = {r_mem[r_cnt][MW-1], r_mem[r_cnt]} + (MW+1)'(RND);
  assign w_shf = w_rnd >>> SHF;

  always_comb begin
    w_pix = w_shf[PW-1:0];
    if (w_shf[MW]) begin
      w_pix = '0;
    end else if (|w_shf[MW-1:PW]) begin
      w_pix = '1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (in_valid) w_next = LOAD;
      LOAD: if (in_valid && r_cnt == 4'd15) w_next = ROW;
      ROW:  if (r_pass == 2'd3) w_next = COL;
      COL:  if (r_pass == 2'd3) w_next = OUT;
      OUT:  if (r_cnt == 4'd15) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_pass      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_next;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      unique case (r_state)
        IDLE: if (in_valid) r_cnt <= 4'd1;
        // Storing index 15 wraps r_cnt to 0, which is the first OUT index.
        LOAD: if (in_valid) r_cnt <= r_cnt + 4'd1;
        ROW,
        COL:  r_pass <= r_pass + 2'd1;
        OUT: begin
          r_cnt       <= r_cnt + 4'd1;
          r_out_valid <= 1'b1;
          r_out_data  <= w_pix;
        end
        default: ;
      endcase
    end
  end

  // Block storage carries no reset: a reset returns the FSM to IDLE and the
  // next block overwrites every entry before it is read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      unique case (r_state)
        IDLE: if (in_valid) r_mem[0] <= w_in_ext;
        LOAD: if (in_valid) r_mem[r_cnt] <= w_in_ext;
        ROW: begin
          for (int unsigned k = 0; k < N; k++) begin
            r_mem[{r_pass, 2'(k)}] <= w_y[k];
          end
        end
        COL: begin
          for (int unsigned k = 0; k < N; k++) begin
            r_mem[{2'(k), r_pass}] <= w_y[k];
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_idct4x4_rx.sv
module tb_idct4x4_rx;

  localparam int CW = 10;
  localparam int PW = 8;

  typedef int blk_t [16];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [CW-1:0] in_data = '0;
  logic          out_valid;
  logic [PW-1:0] out_data;

  idct4x4_rx #(.CW(CW), .PW(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  bit mon_en = 1'b0;
  bit abort_run = 1'b0;
  int unsigned last_e = 0;

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: direct double sum, round, shift, clamp.
  function automatic int hval(input int k, input int i);
    case (k)
      0:       return 1;
      1:       return (i < 2) ? 1 : -1;
      2:       return (i == 0 || i == 3) ? 1 : -1;
      default: return (i % 2 == 0) ? 1 : -1;
    endcase
  endfunction

  function automatic int ref_pix(input blk_t c, input int i, input int j);
    int s = 0;
    int p;
    for (int k = 0; k < 4; k++)
      for (int l = 0; l < 4; l++)
        s += hval(k, i) * hval(l, j) * c[k*4+l];
    p = (s + 8) >>> 4;
    if (p < 0) p = 0;
    if (p > 255) p = 255;
    return p;
  endfunction

  // Monitor: pops the scoreboard on every out_valid, checks idle zeros and
  // the length of each output burst.
  initial begin
    int run = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (out_valid) begin
          run++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pixel: got %0d, expected no output (cycle %0d)", out_data, cyc);
          end else begin
            check("pixel", int'(out_data), exp_q.pop_front());
          end
        end else begin
          check("idle_data_zero", int'(out_data), 0);
          if (run != 0) begin
            if (!abort_run) check("burst_length", run, 16);
            abort_run = 1'b0;
            run = 0;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the last coefficient.
  task automatic send_block(input blk_t c, input int maxgap);
    for (int n = 0; n < 16; n++) begin
      int g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      for (int q = 0; q < g; q++) begin
        in_valid = 1'b0;
        in_data  = CW'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = CW'(c[n]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    last_e = cyc;
  endtask

  // Waits (bounded) for nout output pixels; optionally floods in_valid.
  task automatic wait_out(input bit hold_high, input int nout, output int lat);
    int cnt = 0;
    int budget = 80;
    lat = -1;
    while (cnt < nout && budget > 0) begin
      in_valid = hold_high;
      if (hold_high) in_data = CW'($urandom);
      @(negedge clk);
      budget--;
      if (out_valid) begin
        if (cnt == 0) lat = int'(cyc - last_e);
        cnt++;
      end
    end
    in_valid = 1'b0;
    if (cnt < nout) check("output_timeout", cnt, nout);
  endtask

  task automatic push_const_rows(input int a, input int b, input int cc, input int d);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(a); exp_q.push_back(b);
      exp_q.push_back(cc); exp_q.push_back(d);
    end
  endtask

  initial begin
    blk_t c;
    int lat;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    mon_en = 1'b1;

    // 1: DC only -> flat 10, latency 9
    c = '{default: 0}; c[0] = 160;
    push_const_rows(10, 10, 10, 10);
    send_block(c, 0);
    wait_out(1'b0, 16, lat);
    check("latency", lat, 9);

    // 2: DC plus one horizontal AC
    c = '{default: 0}; c[0] = 160; c[1] = 32;
    push_const_rows(12, 12, 8, 8);
    send_block(c, 0);
    wait_out(1'b0, 16, lat);

    // 3: saturating cases
    c = '{default: 0}; c[0] = 511;
    push_const_rows(32, 32, 32, 32);
    send_block(c, 0);
    wait_out(1'b0, 16, lat);
    c = '{default: 0}; c[0] = -16;
    push_const_rows(0, 0, 0, 0);
    send_block(c, 0);
    wait_out(1'b0, 16, lat);
    c = '{default: 0}; c[0] = 511; c[1] = 511; c[2] = 511; c[3] = 511;
    push_const_rows(128, 0, 0, 0);
    send_block(c, 0);
    wait_out(1'b0, 16, lat);

    // 4: gaps during load, in_valid flooded during processing
    c = '{default: 0}; c[0] = 160; c[1] = 32;
    push_const_rows(12, 12, 8, 8);
    send_block(c, 3);
    wait_out(1'b1, 16, lat);
    c = '{default: 0}; c[0] = 511;
    push_const_rows(32, 32, 32, 32);
    send_block(c, 2);
    wait_out(1'b1, 16, lat);

    // 5a: reset together with the 8th coefficient
    c = '{default: 0}; c[0] = 160;
    for (int n = 0; n < 8; n++) begin
      in_valid = 1'b1;
      in_data  = CW'(c[n] + 100);
      if (n == 7) rst = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_load_out_valid", int'(out_valid), 0);
    check("rst_load_out_data", int'(out_data), 0);
    push_const_rows(10, 10, 10, 10);
    send_block(c, 0);
    wait_out(1'b0, 16, lat);
    check("latency_after_reset", lat, 9);

    // 5b: reset at the 5th output pixel
    c = '{default: 0}; c[0] = 511;
    push_const_rows(32, 32, 32, 32);
    send_block(c, 0);
    wait_out(1'b0, 5, lat);
    rst = 1'b1;
    abort_run = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_out_out_valid", int'(out_valid), 0);
    check("rst_out_out_data", int'(out_data), 0);
    exp_q.delete();
    c = '{default: 0}; c[0] = 160; c[1] = 32;
    push_const_rows(12, 12, 8, 8);
    send_block(c, 0);
    wait_out(1'b0, 16, lat);

    // 6: random blocks, back-to-back against the reference model
    for (int b = 0; b < 200; b++) begin
      for (int n = 0; n < 16; n++) begin
        if (b % 2 == 1)
          c[n] = int'($urandom_range(0, 1023)) - 512;
        else if (n == 0)
          c[n] = int'($urandom_range(0, 511));
        else
          c[n] = int'($urandom_range(0, 63)) - 32;
      end
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          exp_q.push_back(ref_pix(c, i, j));
      send_block(c, 0);
      wait_out(1'b0, 16, lat);
      if (b == 0) check("latency_random", lat, 9);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
